// File: rtl/noise_pkg.sv
// Shared types and constants for the noise generator.
// LFSR tap mask, FSM state encoding and codeword width codes.
package noise_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PICK1 = 2'd1,
      PICK2 = 2'd2
   } state_t;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   localparam logic [1:0] CW_8   = 2'b00;
   localparam logic [1:0] CW_16  = 2'b01;
   localparam logic [1:0] CW_32  = 2'b10;
   localparam logic [1:0] CW_32B = 2'b11;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/lfsr32.sv
// Free-running right-shift Galois LFSR, x^32+x^22+x^2+x+1.
// A zero seed is replaced by SEED so the register never locks up.
module lfsr32
   import noise_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_2468
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] seed,
   output logic [31:0] state
);

   logic [31:0] r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SEED;
      end else if (load) begin
         r_state <= (seed == 32'd0) ? SEED : seed;
      end else begin
         r_state <= lfsr_step(r_state);
      end
   end

   assign state = r_state;

endmodule

// File: rtl/noise_gen.sv
// Error-pattern generator: 0, 1 or 2 set bits at LFSR-chosen positions
// restricted to the active codeword width.
module noise_gen
   import noise_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] SEED       = 32'hACE1_2468
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  seed_load,
   input  logic [31:0]           seed,
   input  logic                  start,
   input  logic [1:0]            num_errors,
   input  logic [1:0]            cw_width,
   output logic                  busy,
   output logic                  noise_valid,
   output logic [DATA_WIDTH-1:0] noise
);

   localparam logic [4:0] DW_MASK = 5'(DATA_WIDTH - 1);

   state_t                r_state;
   logic                  r_two;
   logic [1:0]            r_cw;
   logic [4:0]            r_pos1;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_noise;

   logic [31:0]           w_lfsr;
   logic [31:0]           w_next;
   logic [4:0]            w_cw_mask;
   logic [4:0]            w_pos;
   logic [DATA_WIDTH-1:0] w_oh_pos;
   logic [DATA_WIDTH-1:0] w_oh_pos1;

   lfsr32 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (seed_load),
      .seed  (seed),
      .state (w_lfsr)
   );

   // Positions are taken from the value the LFSR moves to at this edge.
   assign w_next = lfsr_step(w_lfsr);

   always_comb begin
      w_cw_mask = 5'd31;
      unique case (r_cw)
         CW_8:    w_cw_mask = 5'd7;
         CW_16:   w_cw_mask = 5'd15;
         default: w_cw_mask = 5'd31;
      endcase
   end

   assign w_pos     = w_next[4:0] & w_cw_mask & DW_MASK;
   assign w_oh_pos  = DATA_WIDTH'(1) << w_pos;
   assign w_oh_pos1 = DATA_WIDTH'(1) << r_pos1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_two   <= 1'b0;
         r_cw    <= CW_8;
         r_pos1  <= 5'd0;
         r_valid <= 1'b0;
         r_noise <= '0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_two <= num_errors[1];
                  r_cw  <= cw_width;
                  if (num_errors == 2'd0) begin
                     r_noise <= '0;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= PICK1;
                  end
               end
            end
            PICK1: begin
               r_pos1 <= w_pos;
               if (!r_two) begin
                  r_noise <= w_oh_pos;
                  r_valid <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_state <= PICK2;
               end
            end
            PICK2: begin
               if (w_pos != r_pos1) begin
                  r_noise <= w_oh_pos1 | w_oh_pos;
                  r_valid <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = (r_state != IDLE);
   assign noise_valid = r_valid;
   assign noise       = r_noise;

endmodule

// File: tb/tb_noise_gen.sv
// Directed self-checking bench for noise_gen.
// Expected words are hand-derived from the LFSR recurrence.
module tb_noise_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic [31:0] seed;
   logic        start;
   logic [1:0]  num_errors;
   logic [1:0]  cw_width;
   logic        busy;
   logic        noise_valid;
   logic [31:0] noise;

   int vectors = 0;
   int errs    = 0;

   noise_gen #(.DATA_WIDTH(32), .SEED(32'hACE1_2468)) dut (
      .clk         (clk),
      .rst         (rst),
      .seed_load   (seed_load),
      .seed        (seed),
      .start       (start),
      .num_errors  (num_errors),
      .cw_width    (cw_width),
      .busy        (busy),
      .noise_valid (noise_valid),
      .noise       (noise)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic ld, input logic [31:0] sd,
                      input logic [1:0] ne, input logic [1:0] cw);
      seed_load  = ld;
      seed       = sd;
      num_errors = ne;
      cw_width   = cw;
      start      = 1'b1;
      tick();
      seed_load  = 1'b0;
      start      = 1'b0;
   endtask

   initial begin
      int          n;
      logic [1:0]  ne;
      rst        = 1'b1;
      seed_load  = 1'b0;
      seed       = 32'd0;
      start      = 1'b0;
      num_errors = 2'd0;
      cw_width   = 2'b10;
      tick();
      tick();
      chk("rst_noise", noise, 32'h0);
      chk("rst_valid", {31'd0, noise_valid}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_lfsr", dut.u_lfsr.state, 32'hACE1_2468);
      rst = 1'b0;
      tick();

      // seed 1 + start, one error, 32-bit width
      req(1'b1, 32'd1, 2'd1, 2'b10);
      chk("e1_lfsr_e0", dut.u_lfsr.state, 32'h1);
      chk("e1_busy_e0", {31'd0, busy}, 32'h1);
      chk("e1_valid_e0", {31'd0, noise_valid}, 32'h0);
      tick();
      chk("e1_lfsr_e1", dut.u_lfsr.state, 32'h8020_0003);
      chk("e1_noise", noise, 32'h0000_0008);
      chk("e1_valid", {31'd0, noise_valid}, 32'h1);
      chk("e1_busy_e1", {31'd0, busy}, 32'h0);
      tick();
      chk("e1_pulse_end", {31'd0, noise_valid}, 32'h0);

      // same with two errors
      req(1'b1, 32'd1, 2'd2, 2'b10);
      tick();
      chk("e2_busy_e1", {31'd0, busy}, 32'h1);
      chk("e2_valid_e1", {31'd0, noise_valid}, 32'h0);
      tick();
      chk("e2_lfsr_e2", dut.u_lfsr.state, 32'hC030_0002);
      chk("e2_noise", noise, 32'h0000_000C);
      chk("e2_valid", {31'd0, noise_valid}, 32'h1);

      // zero errors: immediate pulse, noise cleared
      req(1'b0, 32'd0, 2'd0, 2'b10);
      chk("e0_noise", noise, 32'h0);
      chk("e0_valid", {31'd0, noise_valid}, 32'h1);
      chk("e0_busy", {31'd0, busy}, 32'h0);

      // code 3 behaves as 2
      req(1'b1, 32'd1, 2'd3, 2'b10);
      tick();
      tick();
      chk("e3_noise", noise, 32'h0000_000C);
      chk("e3_valid", {31'd0, noise_valid}, 32'h1);

      // width masking: next value 0x10 gives pos 0, 0, 16
      req(1'b1, 32'h20, 2'd1, 2'b00);
      tick();
      chk("w8_noise", noise, 32'h0000_0001);
      req(1'b1, 32'h20, 2'd1, 2'b01);
      tick();
      chk("w16_noise", noise, 32'h0000_0001);
      req(1'b1, 32'h20, 2'd1, 2'b11);
      tick();
      chk("w32_noise", noise, 32'h0001_0000);

      // retry: pos 0 twice, then pos 4
      req(1'b1, 32'h20, 2'd2, 2'b00);
      tick();
      tick();
      chk("rt_busy_e2", {31'd0, busy}, 32'h1);
      chk("rt_valid_e2", {31'd0, noise_valid}, 32'h0);
      tick();
      chk("rt_noise", noise, 32'h0000_0011);
      chk("rt_valid", {31'd0, noise_valid}, 32'h1);

      // asynchronous reset while retrying in PICK2
      req(1'b1, 32'h20, 2'd2, 2'b00);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("ar_noise", noise, 32'h0);
      chk("ar_valid", {31'd0, noise_valid}, 32'h0);
      chk("ar_busy", {31'd0, busy}, 32'h0);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ar_no_pulse", {31'd0, noise_valid}, 32'h0);
      end

      // zero seed substitutes SEED
      seed_load = 1'b1;
      seed      = 32'd0;
      tick();
      seed_load = 1'b0;
      chk("zs_lfsr", dut.u_lfsr.state, 32'hACE1_2468);

      // start held high: one pulse every two cycles
      seed_load  = 1'b1;
      seed       = 32'd1;
      num_errors = 2'd1;
      cw_width   = 2'b10;
      start      = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("bb_v0", {31'd0, noise_valid}, 32'h0);
      tick();
      chk("bb_v1", {31'd0, noise_valid}, 32'h1);
      chk("bb_n1", noise, 32'h0000_0008);
      tick();
      chk("bb_v2", {31'd0, noise_valid}, 32'h0);
      chk("bb_b2", {31'd0, busy}, 32'h1);
      tick();
      chk("bb_v3", {31'd0, noise_valid}, 32'h1);
      chk("bb_n3", noise, 32'h0000_0002);
      tick();
      chk("bb_v4", {31'd0, noise_valid}, 32'h0);
      tick();
      chk("bb_v5", {31'd0, noise_valid}, 32'h1);
      chk("bb_n5", noise, 32'h0000_0004);
      start = 1'b0;
      tick();

      // random requests at 8-bit width
      for (int k = 0; k < 2000; k++) begin
         ne = 2'($urandom_range(0, 3));
         req(1'b0, 32'd0, ne, 2'b00);
         n = 0;
         while (!noise_valid && n < 64) begin
            tick();
            n++;
         end
         chk("rnd_done", {31'd0, noise_valid}, 32'h1);
         chk("rnd_mask", {8'd0, noise[31:8]}, 32'h0);
         chk("rnd_pop", $countones(noise),
             (ne == 2'd0) ? 32'd0 : (ne == 2'd1) ? 32'd1 : 32'd2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/noise_gen.md
# noise_gen

Generates the error pattern that the noise adder XORs onto the encoder codeword. On request it produces a DATA_WIDTH noise word with exactly 0, 1 or 2 set bits. Bit positions come from a free-running 32-bit Galois LFSR and are restricted to the active codeword width. The block is the upstream neighbour of the noise adder and is driven by the bench or control register file.

## Interface
- DATA_WIDTH, 32, noise word width; legal values 8, 16, 32
- SEED, 32'hACE1_2468, LFSR reset value; also substituted whenever a zero seed is loaded
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- seed_load  input  1  loads seed into the LFSR at the next edge
- seed  input  32  LFSR seed value
- start  input  1  request a new noise word; accepted only when busy=0
- num_errors  input  2  number of bits to set: 0, 1 or 2; code 3 is treated as 2
- cw_width  input  2  active width: 00=8, 01=16, 10=32, 11=32; clamped to DATA_WIDTH
- busy  output  1  a request is in progress
- noise_valid  output  1  one-cycle pulse when the noise output updates
- noise  output  DATA_WIDTH  registered noise word; holds its value between updates

## Operation
- LFSR
  - Right-shift Galois, polynomial x^32+x^22+x^2+x+1, tap mask 32'h8020_0003.
  - Each edge: if lsb=1, lfsr <= (lfsr>>1)^mask; otherwise lfsr <= lfsr>>1.
  - Advances every cycle regardless of FSM state.
  - seed_load has priority over the advance: lfsr <= seed, or SEED when seed=0.
  - seed_load while busy reloads the LFSR; the FSM continues unaffected.
- Position candidate pos: low bits of the current LFSR value, width set by the latched width.
  - 8-bit width: lfsr[2:0].
  - 16-bit width: lfsr[3:0].
  - 32-bit width: lfsr[4:0].
- FSM states: IDLE, PICK1, PICK2.
- IDLE
  - start=1 latches num_errors and cw_width.
  - If num_errors=0: noise <= 0, noise_valid <= 1, state stays IDLE.
  - Otherwise: state <= PICK1.
- PICK1
  - pos1 <= pos.
  - If num_errors=1: noise <= onehot(pos), noise_valid <= 1, state <= IDLE.
  - Otherwise: state <= PICK2.
- PICK2
  - If pos != pos1: noise <= onehot(pos1)|onehot(pos), noise_valid <= 1, state <= IDLE.
  - If pos = pos1: state stays PICK2 and retries next cycle.
  - Retry count is unbounded; the maximal-length LFSR guarantees termination.
- busy = (state != IDLE).
- start while busy=0 is accepted; start while busy=1 is ignored and not queued.
- Reset values: state IDLE, lfsr SEED, pos1 0, noise 0, noise_valid 0, busy 0.
- Reset asserted mid-operation aborts the request; no noise_valid is issued for it.

## Timing
- Start edge E0 is the edge at which start is sampled in IDLE.
- num_errors=0: noise and noise_valid update at E0; latency 1 cycle.
- num_errors=1: busy from E0; noise and noise_valid update at E1; latency 2 cycles.
- num_errors=2: noise and noise_valid update at E2 at the earliest; each retry adds one cycle.
- noise_valid and busy=0 rise together.
- A start in that same cycle is accepted, so back-to-back requests run with no gap.
- seed_load and start on the same edge: the start is accepted and PICK1 samples the LFSR one advance past the new seed.

## Structure
- Package noise_pkg holds:
  - the state enum (IDLE, PICK1, PICK2);
  - LFSR_TAPS = 32'h8020_0003;
  - the cw_width code constants.
- Sub-module lfsr32: clk, rst, load, seed, state output.
  - Handles zero-seed substitution internally.
- Top level contains the FSM, the width mask and the one-hot decode.

## Test plan
- Reset check: rst pulse mid-PICK2 -> noise=0, noise_valid=0, busy=0 immediately; no pulse afterwards.
- seed_load=1 with seed=1 and start=1 with num_errors=1, cw_width=10, on the same edge E0:
  - lfsr=1 after E0, 32'h8020_0003 after E1;
  - noise=32'h0000_0008 with a valid pulse at E1.
- Same stimulus with num_errors=2:
  - PICK1 takes pos 3 at E1;
  - PICK2 samples 32'hC030_0002 (pos 2) at E2;
  - noise=32'h0000_000C with a valid pulse at E2.
- num_errors=0 and num_errors=3:
  - code 0 -> noise=0 with a valid pulse at E0;
  - code 3 -> behaves as 2, popcount 2.
- Width masking: cw_width=00, 2000 random requests:
  - every noise word has bits [31:8] = 0;
  - popcount matches num_errors;
  - both set positions are distinct.
- start held high continuously: one valid pulse per request, no gaps beyond the stated latencies; starts while busy are ignored. Also seed=0 load -> LFSR equals SEED.
